// File: rtl/mem_responder.sv
// Single-port word memory behind a req/ready handshake with configurable wait states.
// Misaligned or out-of-range accesses get a one-cycle error response.
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic       ZERO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t          state_r;
    logic [3:0]      cnt_r;
    logic            we_r;
    logic [AW-1:0]   idx_r;
    logic [31:0]     wdata_r;
    logic [31:0]     mem_r [0:DEPTH_WORDS-1];

    logic            accept_ok_s;
    logic            commit_s;
    logic            cm_we_s;
    logic [AW-1:0]   cm_idx_s;
    logic [31:0]     cm_wdata_s;

    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < 32'(DEPTH_WORDS));
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return a[AW+1:2];
    endfunction

    // Select the access committed on the edge that enters RESP (live inputs when there are no wait states).
    always_comb begin
        accept_ok_s = addr_ok(addr);
        commit_s    = 1'b0;
        cm_we_s     = we_r;
        cm_idx_s    = idx_r;
        cm_wdata_s  = wdata_r;
        case (state_r)
            IDLE: begin
                if (ZERO_WAIT && req && accept_ok_s) begin
                    commit_s   = rst;
                    cm_we_s    = we;
                    cm_idx_s   = word_idx(addr);
                    cm_wdata_s = wdata;
                end else begin
                    commit_s   = 1'b0;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd1) begin
                    commit_s = rst;
                end else begin
                    commit_s = 1'b0;
                end
            end
            default: commit_s = 1'b0;
        endcase
    end

    // Storage array; deliberately not reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (commit_s && cm_we_s) begin
            mem_r[cm_idx_s] <= cm_wdata_s;
        end
    end

    // Handshake FSM with registered ready/err/busy/rdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            idx_r   <= '0;
            wdata_r <= 32'h0;
            rdata   <= 32'h0;
            ready   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ready <= 1'b0;
                    err   <= 1'b0;
                    if (req) begin
                        we_r    <= we;
                        idx_r   <= word_idx(addr);
                        wdata_r <= wdata;
                        cnt_r   <= WAIT_LOAD;
                        busy    <= 1'b1;
                        if (!accept_ok_s) begin
                            state_r <= ERR;
                            ready   <= 1'b1;
                            err     <= 1'b1;
                        end else if (ZERO_WAIT) begin
                            state_r <= RESP;
                            ready   <= 1'b1;
                            if (!we) begin
                                rdata <= mem_r[cm_idx_s];
                            end
                        end else begin
                            state_r <= WAIT;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        state_r <= RESP;
                        ready   <= 1'b1;
                        if (!we_r) begin
                            rdata <= mem_r[idx_r];
                        end
                    end
                end
                RESP, ERR: begin
                    state_r <= IDLE;
                    cnt_r   <= 4'd0;
                    ready   <= 1'b0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 4'd0;
                    ready   <= 1'b0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a word-array reference model;
// a second instance with zero wait states covers back-to-back operation.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst, req, we, req_z, we_z;
    logic [31:0] addr, wdata, rdata, addr_z, wdata_z, rdata_z;
    logic        ready, err, busy, ready_z, err_z, busy_z;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_mem [0:255];
    logic [31:0] exp_rdata;
    logic [31:0] zdat [0:2];

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .err(err), .busy(busy)
    );

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut_z (
        .clk(clk), .rst(rst), .req(req_z), .we(we_z), .addr(addr_z), .wdata(wdata_z),
        .rdata(rdata_z), .ready(ready_z), .err(err_z), .busy(busy_z)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit addr_valid(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < 32'h400);
    endfunction

    // One transaction on the 2-wait-state instance; optional poke while busy.
    task automatic do_txn(input bit w, input logic [31:0] a, input logic [31:0] d, input bit poke);
        int cyc;
        int extra;
        bit ok;
        ok = addr_valid(a);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        check("busy_accept", {31'b0, busy}, 32'd1);
        if (poke) begin
            req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'hBAD0_BAD0;
        end
        cyc = 1;
        while (!ready && cyc < 20) begin
            @(posedge clk); #1;
            req = 1'b0;
            cyc++;
        end
        req = 1'b0;
        check("latency", 32'(cyc), ok ? 32'd3 : 32'd1);
        if (ok && w) model_mem[a[9:2]] = d;
        if (ok && !w) exp_rdata = model_mem[a[9:2]];
        check("err", {31'b0, err}, {31'b0, !ok});
        check("busy_resp", {31'b0, busy}, 32'd1);
        check("rdata", rdata, exp_rdata);
        @(posedge clk); #1;
        check("ready_drop", {31'b0, ready}, 32'd0);
        check("busy_drop", {31'b0, busy}, 32'd0);
        if (poke) begin
            extra = 0;
            repeat (4) begin
                @(posedge clk); #1;
                extra += int'(ready);
            end
            check("poke_ignored", 32'(extra), 32'd0);
        end
    endtask

    initial begin
        int extra;
        logic [31:0] a;
        bit w;
        rst = 1'b0; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
        req_z = 1'b0; we_z = 1'b0; addr_z = 32'h0; wdata_z = 32'h0;
        exp_rdata = 32'h0;
        #12;
        check("rst_rdata", rdata, 32'h0);
        check("rst_flags", {29'b0, ready, err, busy}, 32'd0);
        check("rst_z_flags", {29'b0, ready_z, err_z, busy_z}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 256; i++) do_txn(1'b1, 32'(i) << 2, $urandom, 1'b0);

        do_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        do_txn(1'b0, 32'h10, 32'h0, 1'b0);
        check("deadbeef", rdata, 32'hDEAD_BEEF);
        do_txn(1'b0, 32'h06, 32'h0, 1'b0);
        do_txn(1'b1, 32'h400, 32'h1, 1'b0);
        do_txn(1'b0, 32'h0, 32'h0, 1'b0);
        do_txn(1'b0, 32'h10, 32'h0, 1'b1);
        do_txn(1'b0, 32'h8, 32'h0, 1'b0);

        // Reset during WAIT aborts the write and suppresses its response.
        do_txn(1'b1, 32'h20, 32'h1234_5678, 1'b0);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h55;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        exp_rdata = 32'h0;
        check("async_rst_flags", {29'b0, ready, err, busy}, 32'd0);
        check("async_rst_rdata", rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        extra = 0;
        repeat (4) begin
            @(posedge clk); #1;
            extra += int'(ready);
        end
        check("aborted_no_ready", 32'(extra), 32'd0);
        do_txn(1'b0, 32'h20, 32'h0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 5))
                0: a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
                1: begin
                    a = $urandom;
                    a[1:0] = 2'b00;
                    if (a < 32'h400) a = a + 32'h400;
                end
                default: a = 32'($urandom_range(0, 255)) << 2;
            endcase
            w = 1'($urandom_range(0, 1));
            do_txn(w, a, $urandom, addr_valid(a) && ($urandom_range(0, 7) == 0));
        end

        // Zero-wait instance with req held high: one response every 2 cycles.
        for (int i = 0; i < 3; i++) zdat[i] = $urandom;
        @(negedge clk);
        req_z = 1'b1; we_z = 1'b1; addr_z = 32'h0; wdata_z = zdat[0];
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("z_ready", {31'b0, ready_z}, 32'd1);
            check("z_err", {31'b0, err_z}, 32'd0);
            if (i >= 3) check("z_rdata", rdata_z, zdat[i-3]);
            if (i < 5) begin
                we_z = (i + 1) < 3;
                addr_z = 32'((i + 1) % 3) << 2;
                wdata_z = zdat[(i + 1) % 3];
            end else begin
                req_z = 1'b0;
            end
            @(posedge clk); #1;
            check("z_gap", {30'b0, ready_z, busy_z}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
